// File: rtl/fpu_norm_round_pkg.sv
// rtl/fpu_norm_round_pkg.sv - shared field positions, limits and flag order for fpu_norm_round
package fpu_norm_round_pkg;

  localparam int MAG_W      = 28;
  localparam int CARRY_BIT  = 27;
  localparam int HIDDEN_BIT = 26;
  localparam int LSB_BIT    = 3;
  localparam int G_BIT      = 2;
  localparam int R_BIT      = 1;
  localparam int S_BIT      = 0;

  localparam int BIAS    = 127;
  localparam int MAX_EXP = 2 * BIAS + 1;

  // Flags = {Overflow, Underflow, Inexact, Zero}
  localparam int FLAG_OVF  = 3;
  localparam int FLAG_UNF  = 2;
  localparam int FLAG_INX  = 1;
  localparam int FLAG_ZERO = 0;

  typedef struct packed {
    logic        sign;
    logic        zero;
    logic [9:0]  exp;
    logic [26:0] norm;
  } s1_t;

endpackage

// File: rtl/fpu_norm_round_lzc32.sv
// rtl/fpu_norm_round_lzc32.sv - 32-bit leading-zero counter with all-zero indication
module lzc32 (
  input  logic [31:0] data,
  output logic [5:0]  count,
  output logic        zero
);

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    count = 6'd32;
    zero  = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (data[i]) begin
        count = 6'(31 - i);
        zero  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fpu_norm_round.sv
// rtl/fpu_norm_round.sv - two-stage elastic normalize (S1) and round-to-nearest-even/pack (S2) pipeline
module fpu_norm_round
  import fpu_norm_round_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        InValid,
  output logic        InReady,
  input  logic        InSign,
  input  logic [7:0]  InExp,
  input  logic [27:0] InMag,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] Result,
  output logic [3:0]  Flags
);

  localparam logic signed [9:0] EXP_HI = 10'(MAX_EXP);

  logic        s1_valid, s2_valid;
  logic        s1_load, s2_load;
  s1_t         s1_d, s1_q;
  logic [5:0]  lz;
  logic        lz_zero;

  assign s2_load  = ~s2_valid | OutReady;
  assign s1_load  = ~s1_valid | s2_load;
  assign InReady  = s1_load;
  assign OutValid = s2_valid;

  // Hidden bit lands at bit 31 of the padded word, so the count is relative to bit 26.
  lzc32 u_lzc (
    .data  ({InMag[HIDDEN_BIT:0], 5'b00000}),
    .count (lz),
    .zero  (lz_zero)
  );

  always_comb begin
    s1_d      = '0;
    s1_d.sign = InSign;
    s1_d.zero = lz_zero & ~InMag[CARRY_BIT];
    if (InMag[CARRY_BIT]) begin
      s1_d.norm = {InMag[CARRY_BIT:R_BIT+1], InMag[R_BIT] | InMag[S_BIT]};
      s1_d.exp  = {2'b00, InExp} + 10'd1;
    end else begin
      s1_d.norm = InMag[HIDDEN_BIT:0] << lz;
      s1_d.exp  = {2'b00, InExp} - {4'b0000, lz};
    end
  end

  logic        g, r, s, rnd;
  logic [24:0] sig;
  logic [9:0]  exp_r;
  logic [31:0] res_d;
  logic [3:0]  flags_d;

  always_comb begin
    g       = s1_q.norm[G_BIT];
    r       = s1_q.norm[R_BIT];
    s       = s1_q.norm[S_BIT];
    rnd     = g & (r | s | s1_q.norm[LSB_BIT]);
    sig     = {1'b0, s1_q.norm[HIDDEN_BIT:LSB_BIT]} + {24'd0, rnd};
    exp_r   = s1_q.exp + {9'd0, sig[24]};
    res_d   = '0;
    flags_d = '0;
    if (s1_q.zero) begin
      flags_d[FLAG_ZERO] = 1'b1;
    end else if ($signed(exp_r) >= EXP_HI) begin
      res_d              = {s1_q.sign, 8'hFF, 23'd0};
      flags_d[FLAG_OVF]  = 1'b1;
      flags_d[FLAG_INX]  = 1'b1;
    end else if ($signed(exp_r) <= 10'sd0) begin
      res_d              = {s1_q.sign, 31'd0};
      flags_d[FLAG_UNF]  = 1'b1;
      flags_d[FLAG_INX]  = 1'b1;
    end else begin
      // On a rounding carry sig[22:0] is already zero, giving significand 1.0.
      res_d              = {s1_q.sign, exp_r[7:0], sig[22:0]};
      flags_d[FLAG_INX]  = g | r | s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
      s2_valid <= 1'b0;
      Result   <= '0;
      Flags    <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= InValid;
        if (InValid) s1_q <= s1_d;
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          Result <= res_d;
          Flags  <= flags_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_norm_round.sv
// tb/tb_fpu_norm_round.sv - randomized and directed self-checking bench for fpu_norm_round
module tb_fpu_norm_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        InValid, InReady, InSign, OutValid, OutReady;
  logic [7:0]  InExp;
  logic [27:0] InMag;
  logic [31:0] Result;
  logic [3:0]  Flags;

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;

  logic [35:0] expq[$];
  logic        stall_prev = 1'b0;
  logic [31:0] held_r;
  logic [3:0]  held_f;

  fpu_norm_round dut (
    .clk      (clk),
    .rst      (rst),
    .InValid  (InValid),
    .InReady  (InReady),
    .InSign   (InSign),
    .InExp    (InExp),
    .InMag    (InMag),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Result   (Result),
    .Flags    (Flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: value = mag * 2^(exp-26-bias); keep 24 significant bits, RNE on the remainder.
  function automatic logic [35:0] ref_model(input logic sign, input logic [7:0] exp, input logic [27:0] mag);
    int     p, e, sh;
    longint keep, rem, half;
    logic   inx;
    p = -1;
    for (int i = 0; i < 28; i++) if (mag[i]) p = i;
    if (p < 0) return {4'b0001, 32'h0};
    e   = int'(exp) + p - 26;
    inx = 1'b0;
    if (p > 23) begin
      sh   = p - 23;
      keep = longint'(mag) >> sh;
      rem  = longint'(mag) & ((longint'(1) << sh) - 1);
      half = longint'(1) << (sh - 1);
      inx  = (rem != 0);
      if (rem > half || (rem == half && keep[0])) keep = keep + 1;
    end else begin
      keep = longint'(mag) << (23 - p);
    end
    if (keep == (longint'(1) << 24)) begin
      keep = longint'(1) << 23;
      e    = e + 1;
    end
    if (e >= 255) return {4'b1010, sign, 8'hFF, 23'd0};
    if (e <= 0)   return {4'b0110, sign, 31'd0};
    return {2'b00, inx, 1'b0, sign, 8'(e), keep[22:0]};
  endfunction

  // One cycle: sample at negedge (handshakes that complete at the next posedge), then step.
  task automatic tick(output logic acc, output logic ir);
    logic [35:0] e;
    @(negedge clk);
    ir  = InReady;
    acc = InValid && InReady;
    if (stall_prev) begin
      check("hold_valid", {31'd0, OutValid}, 32'd1);
      check("hold_result", Result, held_r);
      check("hold_flags", {28'd0, Flags}, {28'd0, held_f});
    end
    if (OutValid && OutReady) begin
      if (expq.size() == 0) begin
        check("unexpected_out", {31'd0, OutValid}, 32'd0);
      end else begin
        e = expq.pop_front();
        check("result", Result, e[31:0]);
        check("flags", {28'd0, Flags}, {28'd0, e[35:32]});
      end
      n_out++;
    end
    if (acc) expq.push_back(ref_model(InSign, InExp, InMag));
    stall_prev = OutValid && !OutReady;
    held_r     = Result;
    held_f     = Flags;
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic s, input logic [7:0] e, input logic [27:0] m,
                          input logic [31:0] xr, input logic [3:0] xf);
    InValid  = 1'b1;
    InSign   = s;
    InExp    = e;
    InMag    = m;
    OutReady = 1'b1;
    @(negedge clk);
    check({tag, "_inready"}, {31'd0, InReady}, 32'd1);
    @(posedge clk); #1;
    InValid = 1'b0;
    @(negedge clk);
    check({tag, "_lat1"}, {31'd0, OutValid}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, {31'd0, OutValid}, 32'd1);
    check({tag, "_result"}, Result, xr);
    check({tag, "_flags"}, {28'd0, Flags}, {28'd0, xf});
    @(posedge clk); #1;
    check({tag, "_alone"}, {31'd0, OutValid}, 32'd0);
  endtask

  task automatic rand_item();
    int mode;
    mode   = $urandom_range(0, 7);
    InSign = 1'($urandom);
    InExp  = (mode < 2) ? 8'($urandom_range(0, 3) + (mode == 0 ? 0 : 252)) : 8'($urandom);
    if (mode == 2)      InMag = 28'd0;
    else if (mode == 3) InMag = 28'h8000000 | 28'($urandom);
    else                InMag = 28'($urandom) >> $urandom_range(0, 27);
  endtask

  logic [27:0] bp_tab [4] = '{28'h4000004, 28'h8000001, 28'h0000123, 28'h7FFFFFC};

  initial begin
    logic acc, ir;
    int   idx, cyc, sent;
    logic pending;

    rst = 1'b1; InValid = 1'b0; InSign = 1'b0; InExp = 8'd0; InMag = 28'd0; OutReady = 1'b0;
    #1;
    check("rst_outvalid", {31'd0, OutValid}, 32'd0);
    check("rst_inready", {31'd0, InReady}, 32'd1);
    check("rst_result", Result, 32'd0);
    check("rst_flags", {28'd0, Flags}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    directed("carry",     1'b0, 8'd127, 28'h8000000, 32'h40000000, 4'b0000);
    directed("cancel",    1'b0, 8'd130, 28'h0000008, 32'h35800000, 4'b0000);
    directed("rnd_even",  1'b0, 8'd127, 28'h4000004, 32'h3F800000, 4'b0010);
    directed("rnd_up",    1'b0, 8'd127, 28'h400000C, 32'h3F800002, 4'b0010);
    directed("rnd_carry", 1'b0, 8'd127, 28'h7FFFFFC, 32'h40000000, 4'b0010);
    directed("overflow",  1'b0, 8'd254, 28'h8000000, 32'h7F800000, 4'b1010);
    directed("underflow", 1'b1, 8'd5,   28'h0000008, 32'h80000000, 4'b0110);
    directed("zero",      1'b1, 8'd77,  28'h0000000, 32'h00000000, 4'b0001);

    // Backpressure: OutReady low while four items arrive back to back.
    idx = 0; n_out = 0; stall_prev = 1'b0;
    for (cyc = 0; cyc < 16; cyc++) begin
      InValid  = (idx < 4);
      InSign   = idx[0];
      InExp    = 8'(100 + idx);
      InMag    = bp_tab[idx & 3];
      OutReady = (cyc >= 4);
      tick(acc, ir);
      if (acc) idx++;
      if (cyc == 2) begin
        check("bp_inready_drop", {31'd0, ir}, 32'd0);
        check("bp_accepts", idx, 2);
      end
    end
    InValid = 1'b0;
    check("bp_all_out", n_out, 4);
    check("bp_queue_empty", expq.size(), 0);

    // Randomized stream with random backpressure.
    n_out = 0; sent = 0; pending = 1'b0; cyc = 0;
    while (n_out < 300 && cyc < 20000) begin
      if (!pending && sent < 300 && $urandom_range(0, 3) != 0) begin
        rand_item();
        pending = 1'b1;
      end
      InValid  = pending;
      OutReady = ($urandom_range(0, 3) != 0);
      tick(acc, ir);
      if (acc) begin
        pending = 1'b0;
        sent++;
      end
      cyc++;
    end
    InValid = 1'b0;
    check("rand_count", n_out, 300);

    // Reset with both stages full.
    OutReady = 1'b0; stall_prev = 1'b0;
    for (int k = 0; k < 2; k++) begin
      InValid = 1'b1; InSign = 1'b0; InExp = 8'd127; InMag = 28'h5000000 + 28'(k);
      tick(acc, ir);
    end
    InValid = 1'b0;
    check("full_before_rst", {31'd0, OutValid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_outvalid", {31'd0, OutValid}, 32'd0);
    check("rst_mid_inready", {31'd0, InReady}, 32'd1);
    check("rst_mid_result", Result, 32'd0);
    check("rst_mid_flags", {28'd0, Flags}, 32'd0);
    expq.delete();
    stall_prev = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    directed("post_rst", 1'b0, 8'd127, 28'h8000000, 32'h40000000, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
